// File: rtl/mem_pkg.sv
// Shared types and constants for the mem_initiator bus front end.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } mem_state_e;

    localparam logic [3:0] MEM_WSTRB_NONE = 4'b0000;

endpackage

// File: rtl/mem_lane.sv
// Byte-lane steering for stores, lane extraction/extension for loads, misalign detect.
// Misalign detection only exists when MISALIGN_TRAP_EN is defined.
module mem_lane
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_signed,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = rdata[{addr_lo, 3'b000} +: 8];
    assign half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        wstrb     = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata;
        case (size)
            MEM_BYTE: begin
                wstrb     = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{is_signed & byte_v[7]}}, byte_v};
            end
            MEM_HALF: begin
                wstrb     = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{is_signed & half_v[15]}}, half_v};
            end
            default: begin
                // size 3 behaves as a word access
                wstrb     = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = rdata;
            end
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        misalign = 1'b0;
        case (size)
            MEM_BYTE: misalign = 1'b0;
            MEM_HALF: misalign = addr_lo[0];
            default:  misalign = (addr_lo != 2'b00);
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: rtl/mem_initiator.sv
// Arbitrates fetch and load/store requests onto one memory bus, one transaction at a time.
// Define MISALIGN_TRAP_EN to trap misaligned accesses instead of silently aligning them.
module mem_initiator
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_addr,
    output logic        fetch_ready,
    output logic [31:0] fetch_rdata,
    input  logic        data_valid,
    input  logic        data_write,
    input  logic [1:0]  data_size,
    input  logic        data_signed,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_ready,
    output logic [31:0] data_rdata,
    output logic        mem_valid,
    output logic        mem_instr,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        trap,
    output logic [1:0]  dbg_state
);

    // Handshake: a client holds *_valid and its fields stable until its *_ready
    // pulses (one cycle) and drops the request in that cycle; on the bus,
    // mem_valid and its fields stay stable until mem_ready is sampled high.

    mem_state_e  state, state_next;
    logic        write_r, trap_r, signed_r, mem_instr_r;
    logic [1:0]  size_r, addr_lo_r;
    logic [31:0] mem_addr_r, mem_wdata_r, rdata_r;
    logic [3:0]  wstrb_r;

    logic        req;
    logic [31:0] sel_addr;
    logic [1:0]  lane_size, lane_addr_lo;
    logic        lane_signed;
    logic [3:0]  lane_wstrb;
    logic [31:0] lane_wdata, lane_rdata;
    logic        lane_misalign;

    assign req      = data_valid | fetch_valid;
    assign sel_addr = data_valid ? data_addr : fetch_addr;

    // In IDLE the lane decodes the incoming request; afterwards it decodes the captured one.
    always_comb begin
        lane_size    = size_r;
        lane_addr_lo = addr_lo_r;
        lane_signed  = signed_r;
        if (state == ST_IDLE) begin
            lane_size    = data_valid ? data_size : MEM_WORD;
            lane_addr_lo = sel_addr[1:0];
            lane_signed  = data_valid & data_signed;
        end
    end

    mem_lane u_lane (
        .size      (lane_size),
        .addr_lo   (lane_addr_lo),
        .is_signed (lane_signed),
        .wdata     (data_wdata),
        .rdata     (mem_rdata),
        .wstrb     (lane_wstrb),
        .wdata_rep (lane_wdata),
        .rdata_ext (lane_rdata),
        .misalign  (lane_misalign)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (req) state_next = lane_misalign ? ST_RESP : ST_BUS;
            ST_BUS:  if (mem_ready) state_next = ST_RESP;
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            write_r     <= 1'b0;
            trap_r      <= 1'b0;
            signed_r    <= 1'b0;
            mem_instr_r <= 1'b0;
            size_r      <= 2'b00;
            addr_lo_r   <= 2'b00;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            wstrb_r     <= MEM_WSTRB_NONE;
            rdata_r     <= '0;
        end else if (state == ST_IDLE && req) begin
            write_r     <= data_valid & data_write;
            trap_r      <= lane_misalign;
            signed_r    <= lane_signed;
            mem_instr_r <= ~data_valid;
            size_r      <= lane_size;
            addr_lo_r   <= lane_addr_lo;
            mem_addr_r  <= {sel_addr[31:2], 2'b00};
            mem_wdata_r <= (data_valid & data_write) ? lane_wdata : '0;
            wstrb_r     <= (data_valid & data_write) ? lane_wstrb : MEM_WSTRB_NONE;
            rdata_r     <= '0;
        end else if (state == ST_BUS && mem_ready) begin
            rdata_r <= write_r ? '0 : lane_rdata;
        end
    end

    assign mem_valid   = (state == ST_BUS);
    assign mem_wstrb   = mem_valid ? wstrb_r : MEM_WSTRB_NONE;
    assign mem_addr    = mem_addr_r;
    assign mem_wdata   = mem_wdata_r;
    assign mem_instr   = mem_instr_r;
    assign fetch_ready = (state == ST_RESP) &&  mem_instr_r;
    assign data_ready  = (state == ST_RESP) && !mem_instr_r;
    assign fetch_rdata = fetch_ready ? rdata_r : '0;
    assign data_rdata  = data_ready  ? rdata_r : '0;
    assign trap        = (state == ST_RESP) && trap_r;
    assign dbg_state   = state;

endmodule

// File: tb/tb_mem_initiator.sv
// Directed bench for mem_initiator: fetch/load/store paths, arbitration, reset abort, misalign.
module tb_mem_initiator;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_addr = '0;
    logic        fetch_ready;
    logic [31:0] fetch_rdata;
    logic        data_valid = 1'b0;
    logic        data_write = 1'b0;
    logic [1:0]  data_size = 2'd0;
    logic        data_signed = 1'b0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic        data_ready;
    logic [31:0] data_rdata;
    logic        mem_valid;
    logic        mem_instr;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = '0;
    logic        trap;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    mem_initiator dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_valid (fetch_valid),
        .fetch_addr  (fetch_addr),
        .fetch_ready (fetch_ready),
        .fetch_rdata (fetch_rdata),
        .data_valid  (data_valid),
        .data_write  (data_write),
        .data_size   (data_size),
        .data_signed (data_signed),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_ready  (data_ready),
        .data_rdata  (data_rdata),
        .mem_valid   (mem_valid),
        .mem_instr   (mem_instr),
        .mem_ready   (mem_ready),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .mem_rdata   (mem_rdata),
        .trap        (trap),
        .dbg_state   (dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request with a responder answering after d extra mem_valid cycles.
    task automatic xact(input string tag, input logic is_f, input logic wr,
                        input logic [1:0] sz, input logic sg, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rsp, input int d,
                        input logic [31:0] e_addr, input logic [31:0] e_wdata,
                        input logic [3:0] e_wstrb, input logic [31:0] e_rdata,
                        input logic e_trap);
        int          cyc;
        int          bus;
        logic        hold_ok;
        logic        done;
        logic [31:0] a0, w0;
        logic [3:0]  s0;
        cyc = 1; bus = 0; hold_ok = 1'b1; done = 1'b0;
        a0 = '0; w0 = '0; s0 = '0;
        if (is_f) begin
            fetch_valid = 1'b1;
            fetch_addr  = addr;
        end else begin
            data_valid  = 1'b1;
            data_write  = wr;
            data_size   = sz;
            data_signed = sg;
            data_addr   = addr;
            data_wdata  = wd;
        end
        mem_ready = 1'b0;
        mem_rdata = rsp;
        tick();
        while (!done && cyc < 40) begin
            if (fetch_ready || data_ready) begin
                done = 1'b1;
            end else begin
                mem_ready = 1'b0;
                if (mem_valid) begin
                    bus++;
                    if (bus == 1) begin
                        check({tag, " mem_addr"}, mem_addr, e_addr);
                        check({tag, " mem_wstrb"}, {28'd0, mem_wstrb}, {28'd0, e_wstrb});
                        check({tag, " mem_instr"}, {31'd0, mem_instr}, {31'd0, is_f});
                        if (wr) check({tag, " mem_wdata"}, mem_wdata, e_wdata);
                        a0 = mem_addr; w0 = mem_wdata; s0 = mem_wstrb;
                    end else if (mem_addr !== a0 || mem_wdata !== w0 || mem_wstrb !== s0
                                 || mem_instr !== is_f) begin
                        hold_ok = 1'b0;
                    end
                    mem_ready = (bus == d + 1);
                end
                tick();
                cyc++;
            end
        end
        mem_ready = 1'b0;
        check({tag, " done"}, {31'd0, done}, 32'd1);
        check({tag, " latency"}, cyc, e_trap ? 32'd1 : 32'(d + 2));
        check({tag, " bus_cycles"}, bus, e_trap ? 32'd0 : 32'(d + 1));
        check({tag, " bus_hold"}, {31'd0, hold_ok}, 32'd1);
        check({tag, " which_ready"}, {30'd0, fetch_ready, data_ready}, is_f ? 32'd2 : 32'd1);
        check({tag, " rdata"}, is_f ? fetch_rdata : data_rdata, e_rdata);
        check({tag, " trap"}, {31'd0, trap}, {31'd0, e_trap});
        check({tag, " valid_in_resp"}, {31'd0, mem_valid}, 32'd0);
        fetch_valid = 1'b0;
        data_valid  = 1'b0;
        tick();
        check({tag, " one_pulse"}, {29'd0, fetch_ready, data_ready, trap}, 32'd0);
    endtask

    initial begin : main
        int          dr_cyc, fr_cyc, dr_n, fr_n, rises, gap_low, late_n;
        logic        prev_v;

        // reset state
        #12;
        check("reset mem_valid", {31'd0, mem_valid}, 32'd0);
        check("reset mem_addr", mem_addr, 32'd0);
        check("reset readies", {29'd0, fetch_ready, data_ready, trap}, 32'd0);
        check("reset state", {30'd0, dbg_state}, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // fetch, store steering, load extension
        xact("fetch14", 1, 0, 2'd2, 0, 32'h14, 32'h0, 32'hff5ff06f, 1,
             32'h14, 32'h0, 4'b0000, 32'hff5ff06f, 0);
        xact("sb3fd", 0, 1, 2'd0, 0, 32'h3fd, 32'h000000a5, 32'h0, 1,
             32'h3fc, 32'ha5a5a5a5, 4'b0010, 32'h0, 0);
        xact("lb3fe", 0, 0, 2'd0, 1, 32'h3fe, 32'h0, 32'h80800000, 1,
             32'h3fc, 32'h0, 4'b0000, 32'hffffff80, 0);
        xact("lbu3fe", 0, 0, 2'd0, 0, 32'h3fe, 32'h0, 32'h80800000, 0,
             32'h3fc, 32'h0, 4'b0000, 32'h00000080, 0);
        xact("lh3fe", 0, 0, 2'd1, 1, 32'h3fe, 32'h0, 32'h80800000, 2,
             32'h3fc, 32'h0, 4'b0000, 32'hffff8080, 0);
        xact("lhu3fe", 0, 0, 2'd1, 0, 32'h3fe, 32'h0, 32'h80800000, 1,
             32'h3fc, 32'h0, 4'b0000, 32'h00008080, 0);
        xact("lb101", 0, 0, 2'd0, 1, 32'h101, 32'h0, 32'h00007f00, 1,
             32'h100, 32'h0, 4'b0000, 32'h0000007f, 0);
        xact("lw_sz3", 0, 0, 2'd3, 1, 32'h3fc, 32'h0, 32'h80800000, 1,
             32'h3fc, 32'h0, 4'b0000, 32'h80800000, 0);
        xact("sh102", 0, 1, 2'd1, 0, 32'h102, 32'hffff1234, 32'h0, 1,
             32'h100, 32'h12341234, 4'b1100, 32'h0, 0);
        xact("sw200", 0, 1, 2'd2, 0, 32'h200, 32'hdeadbeef, 32'h0, 3,
             32'h200, 32'hdeadbeef, 4'b1111, 32'h0, 0);

        // simultaneous load and fetch: data first, gap, then fetch
        data_valid = 1'b1; data_write = 1'b0; data_size = 2'd2; data_signed = 1'b0;
        data_addr = 32'h40; fetch_valid = 1'b1; fetch_addr = 32'h80; mem_ready = 1'b0;
        dr_cyc = -1; fr_cyc = -1; dr_n = 0; fr_n = 0; rises = 0; gap_low = 0; prev_v = 1'b0;
        tick();
        for (int c = 1; c <= 10; c++) begin
            mem_ready = 1'b0;
            if (data_ready) begin
                dr_n++; dr_cyc = c;
                check("both data_rdata", data_rdata, 32'h11111111);
                data_valid = 1'b0;
            end
            if (fetch_ready) begin
                fr_n++; fr_cyc = c;
                check("both fetch_rdata", fetch_rdata, 32'h22222222);
                fetch_valid = 1'b0;
            end
            if (mem_valid && !prev_v) begin
                rises++;
                if (rises == 1) check("both first", {mem_instr, mem_addr[30:0]}, 32'h00000040);
                else            check("both second", {mem_instr, mem_addr[30:0]}, 32'h80000080);
            end
            if (!mem_valid && rises == 1) gap_low++;
            if (mem_valid && prev_v) mem_ready = 1'b1;
            mem_rdata = mem_instr ? 32'h22222222 : 32'h11111111;
            prev_v = mem_valid;
            tick();
        end
        mem_ready = 1'b0;
        check("both data_ready cycle", dr_cyc, 32'd3);
        check("both fetch_ready cycle", fr_cyc, 32'd7);
        check("both pulse counts", {dr_n[15:0], fr_n[15:0]}, {16'd1, 16'd1});
        check("both rises", rises, 32'd2);
        check("both gap", gap_low, 32'd2);

        // reset in the 3rd wait cycle of a slow store
        data_valid = 1'b1; data_write = 1'b1; data_size = 2'd2; data_signed = 1'b0;
        data_addr = 32'h300; data_wdata = 32'hcafef00d; mem_ready = 1'b0;
        tick();
        check("slow c1", {mem_valid, 27'd0, mem_wstrb}, 32'h8000000f);
        check("slow c1 addr", mem_addr, 32'h300);
        tick();
        check("slow c2 hold", {mem_valid, 27'd0, mem_wstrb}, 32'h8000000f);
        check("slow c2 addr", mem_addr, 32'h300);
        tick();
        check("slow c3 hold", mem_wdata, 32'hcafef00d);
        #2;
        reset = 1'b0;
        data_valid = 1'b0;
        #1;
        check("rst_mid mem_valid", {31'd0, mem_valid}, 32'd0);
        check("rst_mid mem_addr", mem_addr, 32'd0);
        check("rst_mid mem_wdata", mem_wdata, 32'd0);
        check("rst_mid wstrb_instr", {27'd0, mem_instr, mem_wstrb}, 32'd0);
        check("rst_mid readies", {29'd0, fetch_ready, data_ready, trap}, 32'd0);
        check("rst_mid rdata", data_rdata | fetch_rdata, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        late_n = 0;
        for (int c = 0; c < 5; c++) begin
            mem_ready = (c < 2);
            if (data_ready || mem_valid) late_n++;
            tick();
        end
        mem_ready = 1'b0;
        check("rst_mid no_ready_after", late_n, 32'd0);

        // misaligned accesses
`ifdef MISALIGN_TRAP_EN
        xact("lw3fd_trap", 0, 0, 2'd2, 0, 32'h3fd, 32'h0, 32'h12345678, 1,
             32'h0, 32'h0, 4'b0000, 32'h0, 1);
        xact("lh3fd_trap", 0, 0, 2'd1, 1, 32'h3fd, 32'h0, 32'h12348765, 1,
             32'h0, 32'h0, 4'b0000, 32'h0, 1);
        xact("fetch16_trap", 1, 0, 2'd2, 0, 32'h16, 32'h0, 32'habcd0123, 1,
             32'h0, 32'h0, 4'b0000, 32'h0, 1);
        xact("sb3ff_ok", 0, 1, 2'd0, 0, 32'h3ff, 32'h0000003c, 32'h0, 1,
             32'h3fc, 32'h3c3c3c3c, 4'b1000, 32'h0, 0);
`else
        xact("lw3fd", 0, 0, 2'd2, 0, 32'h3fd, 32'h0, 32'h12345678, 1,
             32'h3fc, 32'h0, 4'b0000, 32'h12345678, 0);
        xact("lh3fd", 0, 0, 2'd1, 1, 32'h3fd, 32'h0, 32'h12348765, 1,
             32'h3fc, 32'h0, 4'b0000, 32'hffff8765, 0);
        xact("fetch16", 1, 0, 2'd2, 0, 32'h16, 32'h0, 32'habcd0123, 1,
             32'h14, 32'h0, 4'b0000, 32'habcd0123, 0);
        xact("sb3ff", 0, 1, 2'd0, 0, 32'h3ff, 32'h0000003c, 32'h0, 1,
             32'h3fc, 32'h3c3c3c3c, 4'b1000, 32'h0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
